// File: rtl/sram_arbiter_if.sv
// rtl/sram_arbiter_if.sv - requester and SRAM-controller signal bundle for sram_arbiter
interface sram_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              p0_req;
    logic              p0_we;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata;
    logic [DATA_W-1:0] p0_rdata;
    logic              p0_ack;
    logic              p0_err;

    logic              p1_req;
    logic              p1_we;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata;
    logic [DATA_W-1:0] p1_rdata;
    logic              p1_ack;
    logic              p1_err;

    logic              mem_wr_en;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_write_data;
    logic [DATA_W-1:0] mem_read_data;
    logic              mem_ready;

    logic              busy;
    logic              grant;

    // Arbiter side
    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        input  mem_read_data, mem_ready,
        output p0_rdata, p0_ack, p0_err,
        output p1_rdata, p1_ack, p1_err,
        output mem_wr_en, mem_rd_en, mem_address, mem_write_data,
        output busy, grant
    );

    // Requesters plus controller side
    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        output p1_req, p1_we, p1_addr, p1_wdata,
        output mem_read_data, mem_ready,
        input  p0_rdata, p0_ack, p0_err,
        input  p1_rdata, p1_ack, p1_err,
        input  mem_wr_en, mem_rd_en, mem_address, mem_write_data,
        input  busy, grant
    );
endinterface

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-port SRAM controller arbiter with timeout; ARB_FIXED_PRIO_EN selects fixed port-0 priority
module sram_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic          clk,
    input  logic          rst,
    sram_arbiter_if.slave bus
);
    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              grant_q, grant_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wr_en_q, wr_en_d;
    logic              rd_en_q, rd_en_d;
    logic              busy_q, busy_d;
    logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d;
    logic [DATA_W-1:0] p1_rdata_q, p1_rdata_d;
    logic              p0_ack_q, p0_ack_d;
    logic              p1_ack_q, p1_ack_d;
    logic              p0_err_q, p0_err_d;
    logic              p1_err_q, p1_err_d;
`ifndef ARB_FIXED_PRIO_EN
    logic              last_q, last_d;
`endif

    logic              winner;
    logic              win_we;
    logic              done;
    logic              timeout;

    always_comb begin
`ifdef ARB_FIXED_PRIO_EN
        winner = ~bus.p0_req;
`else
        // On contention the port that was not served last goes first.
        winner = (bus.p0_req && bus.p1_req) ? ~last_q : ~bus.p0_req;
`endif
        win_we  = winner ? bus.p1_we : bus.p0_we;
        done    = bus.mem_ready;
        timeout = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
    end

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        grant_d    = grant_q;
        cnt_d      = cnt_q;
        wr_en_d    = wr_en_q;
        rd_en_d    = rd_en_q;
        busy_d     = busy_q;
        p0_rdata_d = p0_rdata_q;
        p1_rdata_d = p1_rdata_q;
        p0_ack_d   = 1'b0;
        p1_ack_d   = 1'b0;
        p0_err_d   = 1'b0;
        p1_err_d   = 1'b0;
`ifndef ARB_FIXED_PRIO_EN
        last_d     = last_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (bus.p0_req || bus.p1_req) begin
                    state_d = S_BUSY;
                    we_d    = win_we;
                    addr_d  = winner ? bus.p1_addr  : bus.p0_addr;
                    wdata_d = winner ? bus.p1_wdata : bus.p0_wdata;
                    grant_d = winner;
`ifndef ARB_FIXED_PRIO_EN
                    last_d  = winner;
`endif
                    cnt_d   = '0;
                    wr_en_d = win_we;
                    rd_en_d = ~win_we;
                    busy_d  = 1'b1;
                end
            end

            S_BUSY: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Enables must drop on the completion edge, or the controller
                // starts a second access from its idle state.
                if (done || timeout) begin
                    state_d = S_RESP;
                    wr_en_d = 1'b0;
                    rd_en_d = 1'b0;
                    if (grant_q) begin
                        p1_ack_d = 1'b1;
                        p1_err_d = ~done;
                    end else begin
                        p0_ack_d = 1'b1;
                        p0_err_d = ~done;
                    end
                    if (done && !we_q) begin
                        if (grant_q) begin
                            p1_rdata_d = bus.mem_read_data;
                        end else begin
                            p0_rdata_d = bus.mem_read_data;
                        end
                    end
                end
            end

            S_RESP: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = S_IDLE;
                wr_en_d = 1'b0;
                rd_en_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            grant_q    <= 1'b0;
            cnt_q      <= '0;
            wr_en_q    <= 1'b0;
            rd_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            p0_rdata_q <= '0;
            p1_rdata_q <= '0;
            p0_ack_q   <= 1'b0;
            p1_ack_q   <= 1'b0;
            p0_err_q   <= 1'b0;
            p1_err_q   <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
            last_q     <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            grant_q    <= grant_d;
            cnt_q      <= cnt_d;
            wr_en_q    <= wr_en_d;
            rd_en_q    <= rd_en_d;
            busy_q     <= busy_d;
            p0_rdata_q <= p0_rdata_d;
            p1_rdata_q <= p1_rdata_d;
            p0_ack_q   <= p0_ack_d;
            p1_ack_q   <= p1_ack_d;
            p0_err_q   <= p0_err_d;
            p1_err_q   <= p1_err_d;
`ifndef ARB_FIXED_PRIO_EN
            last_q     <= last_d;
`endif
        end
    end

    assign bus.mem_wr_en      = wr_en_q;
    assign bus.mem_rd_en      = rd_en_q;
    assign bus.mem_address    = addr_q;
    assign bus.mem_write_data = wdata_q;
    assign bus.p0_rdata       = p0_rdata_q;
    assign bus.p1_rdata       = p1_rdata_q;
    assign bus.p0_ack         = p0_ack_q;
    assign bus.p1_ack         = p1_ack_q;
    assign bus.p0_err         = p0_err_q;
    assign bus.p1_err         = p1_err_q;
    assign bus.busy           = busy_q;
    assign bus.grant          = grant_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - directed self-checking bench for sram_arbiter with a 6-cycle controller model
module tb_sram_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Controller model: ready idles high, goes low once enabled, pulses in the 6th enabled cycle.
    logic [7:0]    ctl_cnt;
    logic          stuck;
    logic [DW-1:0] mem_word;
    logic          ctl_en;
    assign ctl_en = bus.mem_wr_en | bus.mem_rd_en;
    always @(posedge clk or posedge rst) begin
        if (rst)         ctl_cnt <= 8'd0;
        else if (ctl_en) ctl_cnt <= ctl_cnt + 8'd1;
        else             ctl_cnt <= 8'd0;
    end
    assign bus.mem_ready     = stuck ? 1'b0 : (ctl_en ? (ctl_cnt == 8'd5) : 1'b1);
    assign bus.mem_read_data = mem_word;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int rd_cnt, wr_cnt, ok_cnt, en_cnt, cyc;
    int ack_port[4];
    int ack_cyc[4];
    int n_ack;
    logic seen_ack, seen_err;
    int exp_port[4];

    initial begin
        rst = 1'b1;
        stuck = 1'b0;
        mem_word = '0;
        bus.p0_req = 1'b0; bus.p0_we = 1'b0; bus.p0_addr = '0; bus.p0_wdata = '0;
        bus.p1_req = 1'b0; bus.p1_we = 1'b0; bus.p1_addr = '0; bus.p1_wdata = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reset state
        chk("rst_busy", bus.busy, 0);
        chk("rst_grant", bus.grant, 0);
        chk("rst_wr_en", bus.mem_wr_en, 0);
        chk("rst_rd_en", bus.mem_rd_en, 0);
        chk("rst_addr", bus.mem_address, 0);
        chk("rst_acks", {bus.p0_ack, bus.p1_ack, bus.p0_err, bus.p1_err}, 0);
        chk("rst_p0_rdata", bus.p0_rdata, 0);
        chk("rst_p1_rdata", bus.p1_rdata, 0);

        // p0 read 0x400
        mem_word = 32'h1234_5678;
        bus.p0_we = 1'b0; bus.p0_addr = 32'h400; bus.p0_req = 1'b1;
        rd_cnt = 0; wr_cnt = 0; ok_cnt = 0;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (bus.mem_rd_en) rd_cnt++;
            if (bus.mem_wr_en) wr_cnt++;
            if (bus.mem_rd_en && bus.mem_address == 32'h400) ok_cnt++;
        end
        chk("t1_rd_cycles", rd_cnt, 6);
        chk("t1_wr_cycles", wr_cnt, 0);
        chk("t1_addr_cycles", ok_cnt, 6);
        tick();
        chk("t1_p0_ack", bus.p0_ack, 1);
        chk("t1_p0_err", bus.p0_err, 0);
        chk("t1_p0_rdata", bus.p0_rdata, 32'h1234_5678);
        chk("t1_p1_ack", bus.p1_ack, 0);
        chk("t1_en_resp", {bus.mem_wr_en, bus.mem_rd_en}, 0);
        bus.p0_req = 1'b0;
        tick();
        chk("t1_ack_pulse", bus.p0_ack, 0);
        chk("t1_idle", bus.busy, 0);

        // p1 write 0x408
        mem_word = 32'hAAAA_5555;
        bus.p1_we = 1'b1; bus.p1_addr = 32'h408; bus.p1_wdata = 32'hDEAD_BEEF; bus.p1_req = 1'b1;
        rd_cnt = 0; wr_cnt = 0;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (bus.mem_rd_en) rd_cnt++;
            if (bus.mem_wr_en && bus.mem_write_data == 32'hDEAD_BEEF && bus.mem_address == 32'h408) wr_cnt++;
        end
        chk("t2_wr_cycles", wr_cnt, 6);
        chk("t2_rd_cycles", rd_cnt, 0);
        tick();
        chk("t2_p1_ack", bus.p1_ack, 1);
        chk("t2_p1_err", bus.p1_err, 0);
        chk("t2_p1_rdata", bus.p1_rdata, 0);
        chk("t2_p0_ack", bus.p0_ack, 0);
        chk("t2_p0_rdata", bus.p0_rdata, 32'h1234_5678);
        chk("t2_grant", bus.grant, 1);
        chk("t2_wr_resp", bus.mem_wr_en, 0);
        bus.p1_req = 1'b0;
        tick();
        chk("t2_wr_idle", bus.mem_wr_en, 0);

        // Both requesting from reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mem_word = 32'h0000_0042;
        bus.p0_we = 1'b0; bus.p0_addr = 32'h400;
        bus.p1_we = 1'b0; bus.p1_addr = 32'h408;
        bus.p0_req = 1'b1; bus.p1_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ack_port[i] = -1;
            ack_cyc[i] = -1;
        end
`ifdef ARB_FIXED_PRIO_EN
        exp_port = '{0, 0, 0, 0};
`else
        exp_port = '{0, 1, 0, 1};
`endif
        n_ack = 0;
        cyc = 0;
        while (n_ack < 4 && cyc < 40) begin
            tick();
            cyc++;
            if (bus.p0_ack || bus.p1_ack) begin
                ack_port[n_ack] = bus.p1_ack ? 1 : 0;
                ack_cyc[n_ack] = cyc;
                n_ack++;
                if (n_ack == 4) begin
                    bus.p0_req = 1'b0;
                    bus.p1_req = 1'b0;
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t3_port%0d", i), ack_port[i], exp_port[i]);
            chk($sformatf("t3_cycle%0d", i), ack_cyc[i], 7 + 8 * i);
        end
        bus.p0_req = 1'b0;
        bus.p1_req = 1'b0;
        tick();
        tick();
        chk("t3_idle", bus.busy, 0);

        // p1 raised during a p0 access
        mem_word = 32'h1111_2222;
        bus.p0_we = 1'b0; bus.p0_addr = 32'h400; bus.p0_req = 1'b1;
        bus.p1_we = 1'b0; bus.p1_addr = 32'h500;
        ok_cnt = 0;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (bus.mem_rd_en && bus.mem_address == 32'h400 && bus.grant == 1'b0) ok_cnt++;
            if (c == 2) bus.p1_req = 1'b1;
        end
        chk("t4_p0_addr_cycles", ok_cnt, 6);
        tick();
        chk("t4_p0_ack", bus.p0_ack, 1);
        chk("t4_p0_rdata", bus.p0_rdata, 32'h1111_2222);
        chk("t4_p1_ack_early", bus.p1_ack, 0);
        bus.p0_req = 1'b0;
        mem_word = 32'hCAFE_F00D;
        tick();
        chk("t4_c8_rd_en", bus.mem_rd_en, 0);
        chk("t4_c8_addr", bus.mem_address, 32'h400);
        tick();
        chk("t4_c9_grant", bus.grant, 1);
        chk("t4_c9_rd_en", bus.mem_rd_en, 1);
        chk("t4_c9_addr", bus.mem_address, 32'h500);
        for (int c = 10; c <= 15; c++) tick();
        chk("t4_p1_ack", bus.p1_ack, 1);
        chk("t4_p1_rdata", bus.p1_rdata, 32'hCAFE_F00D);
        chk("t4_p0_rdata_kept", bus.p0_rdata, 32'h1111_2222);
        chk("t4_p0_ack_quiet", bus.p0_ack, 0);
        bus.p1_req = 1'b0;
        tick();

        // Timeout with ready stuck low
        stuck = 1'b1;
        mem_word = 32'h9999_9999;
        bus.p0_addr = 32'h600; bus.p0_req = 1'b1;
        en_cnt = 0; cyc = 0; seen_ack = 1'b0; seen_err = 1'b0;
        while (!seen_ack && cyc < 40) begin
            tick();
            cyc++;
            if (bus.mem_rd_en || bus.mem_wr_en) en_cnt++;
            if (bus.p0_ack) begin
                seen_ack = 1'b1;
                seen_err = bus.p0_err;
            end
        end
        chk("t5_ack_seen", seen_ack, 1);
        chk("t5_err", seen_err, 1);
        chk("t5_en_cycles", en_cnt, 16);
        chk("t5_ack_cycle", cyc, 17);
        chk("t5_rdata_kept", bus.p0_rdata, 32'h1111_2222);
        bus.p0_req = 1'b0;
        tick();
        chk("t5_pulse", {bus.p0_ack, bus.p0_err}, 0);
        stuck = 1'b0;
        mem_word = 32'h5A5A_0001;
        bus.p0_req = 1'b1;
        cyc = 0; seen_ack = 1'b0; seen_err = 1'b1;
        while (!seen_ack && cyc < 20) begin
            tick();
            cyc++;
            if (bus.p0_ack) begin
                seen_ack = 1'b1;
                seen_err = bus.p0_err;
            end
        end
        chk("t5_next_cycle", cyc, 7);
        chk("t5_next_err", seen_err, 0);
        chk("t5_next_rdata", bus.p0_rdata, 32'h5A5A_0001);
        bus.p0_req = 1'b0;
        tick();

        // Reset in cycle 3 of a read
        mem_word = 32'h7654_3210;
        bus.p0_addr = 32'h700; bus.p0_req = 1'b1;
        tick();
        tick();
        tick();
        chk("t6_rd_before", bus.mem_rd_en, 1);
        rst = 1'b1;
        #1;
        chk("t6_rd_async", bus.mem_rd_en, 0);
        chk("t6_busy_async", bus.busy, 0);
        tick();
        chk("t6_no_ack", bus.p0_ack, 0);
        rst = 1'b0;
        cyc = 0; seen_ack = 1'b0; seen_err = 1'b1;
        while (!seen_ack && cyc < 20) begin
            tick();
            cyc++;
            if (bus.p0_ack) begin
                seen_ack = 1'b1;
                seen_err = bus.p0_err;
            end
        end
        chk("t6_ack_cycle", cyc, 7);
        chk("t6_err", seen_err, 0);
        chk("t6_rdata", bus.p0_rdata, 32'h7654_3210);
        bus.p0_req = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
